sp_mem_arbiter: RTL and testbench
=================================

Name: sp_mem_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters, A and B.
- Uses round-robin arbitration with a valid/ready request handshake.
- Drives the memory's wr_en/rd_en/address/wr_data command interface from registers.
- Routes read data back to the requester that issued the read, using a latency-matched tag pipeline.

Parameters:
- DATA_WIDTH, 8, data width in bits.
- ADDR_WIDTH, 8, address width in bits.
- RD_LATENCY, 2, cycles from memory command cycle to valid i_rd_data (≥1).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- i_a_valid  in  1  requester A command valid.
- i_a_wr  in  1  A: 1=write, 0=read.
- i_a_addr  in  ADDR_WIDTH  A address.
- i_a_wdata  in  DATA_WIDTH  A write data.
- o_a_ready  out  1  A command accepted this cycle.
- o_a_rvalid  out  1  A read data valid.
- o_a_rdata  out  DATA_WIDTH  A read data.
- i_b_valid, i_b_wr, i_b_addr, i_b_wdata, o_b_ready, o_b_rvalid, o_b_rdata: same as A, for requester B.
- o_wr_en  out  1  memory write enable.
- o_rd_en  out  1  memory read enable.
- o_address  out  ADDR_WIDTH  memory address.
- o_wr_data  out  DATA_WIDTH  memory write data.
- i_rd_data  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset (i_rst_n=0 at posedge): all of the following clear to 0.
  - o_wr_en, o_rd_en, o_address, o_wr_data.
  - Tag pipeline; last_grant=B, so A wins the first contention.
  - With the optional feature compiled in, stats counters.
  - o_x_ready are forced to 0 while i_rst_n=0.
- Arbitration (combinational within cycle):
  - Only one of A or B valid: that one gets ready.
  - Both valid: the requester not equal to last_grant gets ready.
  - Neither valid: no ready.
  - At most one ready per cycle; the memory accepts one command every cycle, so there are no bubbles.
- Transfer occurs at a posedge with valid&ready.
  - Same edge: last_grant <= winner.
  - Same edge: o_wr_en <= wr, o_rd_en <= ~wr, o_address/o_wr_data <= winner fields.
  - Command is therefore presented to memory the cycle after acceptance.
  - No transfer: o_wr_en=o_rd_en=0; o_address/o_wr_data hold their last values.
- Requesters hold valid and fields stable until ready. Dropping valid before ready is allowed (request withdrawn).
- Read return uses a tag pipeline of RD_LATENCY entries {vld, id}.
  - Entry 0 loads {o_rd_en, id of command} each cycle; entries shift each cycle.
  - Tail valid with id=A: o_a_rvalid=1. Same for B.
  - o_a_rdata = o_b_rdata = i_rd_data (combinational pass-through).
  - rvalid therefore rises RD_LATENCY cycles after the o_rd_en cycle, i.e. RD_LATENCY+1 cycles after acceptance.
- Writes produce no response.
- Back-to-back reads from alternating requesters return in order, one per cycle.
- Write followed by read to the same address is ordered by issue order. The memory's read-after-write semantics apply unchanged.
- Reset mid-operation: in-flight reads are dropped; no rvalid is produced for them after reset.
- Address wrap: no arithmetic; address passes through unmodified.

Optional Feature:
- Macro SP_MEM_ARB_STATS_EN.
- Defined: adds outputs o_a_grant_cnt and o_b_grant_cnt (16 bits each).
  - Each increments on its requester's accepted transfer and saturates at 16'hFFFF.
  - Also adds o_conflict_cnt (16 bits, saturating), which increments each cycle both valids are high.
  - All clear on reset.
- Undefined: these ports and registers do not exist; functional behaviour is identical.

Decomposition:
- Package sp_mem_arb_pkg holds:
  - typedef enum logic {REQ_A, REQ_B} req_id_t;
  - typedef struct {wr, addr, wdata} mem_cmd_t, parameterised by localparams in the package;
  - localparam STAT_W=16.
- One sub-module, sp_mem_arb_tagpipe: RD_LATENCY-deep shift register of {vld, id}, with synchronous active-low clear.

Test Plan:
- Reset then A only: write addr 8'h10 data 8'hA5 → o_a_ready=1 same cycle; next cycle o_wr_en=1, o_address=10, o_wr_data=A5; B never ready.
- Both valid continuously, A reads 8'h10, B reads 8'h20 → grants alternate A,B,A,B starting with A; o_rd_en every cycle; rvalid alternates A,B from RD_LATENCY+1 cycles after first accept; A gets A5 at 10.
- A valid held while B wins contention → A stays ready=0 one cycle, accepted next cycle; its fields observed unchanged on o_address.
- Read accepted, i_rst_n low one cycle before return → no o_a_rvalid/o_b_rvalid; outputs 0 during reset; first post-reset contention grants A.
- Idle (no valids) 5 cycles → o_wr_en=o_rd_en=0, no rvalid.
- With SP_MEM_ARB_STATS_EN defined: 6 contention cycles → o_a_grant_cnt=3, o_b_grant_cnt=3, o_conflict_cnt=6; forced 70000 grants saturate at FFFF.

Source files
------------

// File: rtl/sp_mem_arb_pkg.sv
// Shared types and constants for the two-requester single-port memory arbiter.
package sp_mem_arb_pkg;

    typedef enum logic {REQ_A, REQ_B} req_id_t;

    localparam int CMD_ADDR_W = 8;
    localparam int CMD_DATA_W = 8;
    localparam int STAT_W     = 16;

    typedef struct packed {
        logic                  wr;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/sp_mem_arb_tagpipe.sv
// Latency-matched shift register of {valid, requester id} used to steer read data
// back to whichever requester issued the read.
module sp_mem_arb_tagpipe
    import sp_mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_vld,
    input  req_id_t i_id,
    output logic    o_vld,
    output req_id_t o_id
);

    logic [DEPTH-1:0] vld;
    req_id_t          id [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) id[i] <= REQ_A;
        end else begin
            vld[0] <= i_vld;
            id[0]  <= i_id;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                id[i]  <= id[i-1];
            end
        end
    end

    assign o_vld = vld[DEPTH-1];
    assign o_id  = id[DEPTH-1];

endmodule

// File: rtl/sp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between requesters A and B.
// Define SP_MEM_ARB_STATS_EN to add saturating grant and conflict counters.
module sp_mem_arbiter
    import sp_mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_a_valid,
    input  logic                  i_a_wr,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    output logic                  o_a_ready,
    output logic                  o_a_rvalid,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    input  logic                  i_b_valid,
    input  logic                  i_b_wr,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    output logic                  o_b_ready,
    output logic                  o_b_rvalid,
    output logic [DATA_WIDTH-1:0] o_b_rdata,
    output logic                  o_wr_en,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic [DATA_WIDTH-1:0] i_rd_data
`ifdef SP_MEM_ARB_STATS_EN
   ,output logic [STAT_W-1:0]     o_a_grant_cnt,
    output logic [STAT_W-1:0]     o_b_grant_cnt,
    output logic [STAT_W-1:0]     o_conflict_cnt
`endif
);

    req_id_t last_grant;
    req_id_t cmd_id;
    req_id_t tail_id;
    logic    tail_vld;

    // On contention the requester that did not win last time gets the slot.
    assign o_a_ready = i_rst_n && i_a_valid && (!i_b_valid || last_grant == REQ_B);
    assign o_b_ready = i_rst_n && i_b_valid && (!i_a_valid || last_grant == REQ_A);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_wr_en    <= 1'b0;
            o_rd_en    <= 1'b0;
            o_address  <= '0;
            o_wr_data  <= '0;
            last_grant <= REQ_B;
            cmd_id     <= REQ_A;
        end else begin
            o_wr_en <= 1'b0;
            o_rd_en <= 1'b0;
            if (o_a_ready) begin
                o_wr_en    <= i_a_wr;
                o_rd_en    <= !i_a_wr;
                o_address  <= i_a_addr;
                o_wr_data  <= i_a_wdata;
                last_grant <= REQ_A;
                cmd_id     <= REQ_A;
            end else if (o_b_ready) begin
                o_wr_en    <= i_b_wr;
                o_rd_en    <= !i_b_wr;
                o_address  <= i_b_addr;
                o_wr_data  <= i_b_wdata;
                last_grant <= REQ_B;
                cmd_id     <= REQ_B;
            end
        end
    end

    sp_mem_arb_tagpipe #(
        .DEPTH (RD_LATENCY)
    ) u_tagpipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vld   (o_rd_en),
        .i_id    (cmd_id),
        .o_vld   (tail_vld),
        .o_id    (tail_id)
    );

    assign o_a_rvalid = tail_vld && (tail_id == REQ_A);
    assign o_b_rvalid = tail_vld && (tail_id == REQ_B);
    assign o_a_rdata  = i_rd_data;
    assign o_b_rdata  = i_rd_data;

`ifdef SP_MEM_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_a_grant_cnt  <= '0;
            o_b_grant_cnt  <= '0;
            o_conflict_cnt <= '0;
        end else begin
            if (o_a_ready && o_a_grant_cnt != STAT_MAX)
                o_a_grant_cnt <= o_a_grant_cnt + 1'b1;
            if (o_b_ready && o_b_grant_cnt != STAT_MAX)
                o_b_grant_cnt <= o_b_grant_cnt + 1'b1;
            if (i_a_valid && i_b_valid && o_conflict_cnt != STAT_MAX)
                o_conflict_cnt <= o_conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed self-checking bench for sp_mem_arbiter with a 2-cycle-latency memory model.
// Stats checks run only when SP_MEM_ARB_STATS_EN is defined.
module tb_sp_mem_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_a_valid, i_a_wr, i_b_valid, i_b_wr;
    logic [7:0] i_a_addr, i_a_wdata, i_b_addr, i_b_wdata;
    logic       o_a_ready, o_a_rvalid, o_b_ready, o_b_rvalid;
    logic [7:0] o_a_rdata, o_b_rdata;
    logic       o_wr_en, o_rd_en;
    logic [7:0] o_address, o_wr_data, i_rd_data;
`ifdef SP_MEM_ARB_STATS_EN
    logic [15:0] o_a_grant_cnt, o_b_grant_cnt, o_conflict_cnt;
`endif

    int checkCnt = 0;
    int passCnt  = 0;

    logic [7:0] mem [256];
    logic [7:0] rdPipe1, rdPipe2;

    always #5 i_clk = ~i_clk;

    sp_mem_arbiter #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (8),
        .RD_LATENCY (2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_a_valid  (i_a_valid),
        .i_a_wr     (i_a_wr),
        .i_a_addr   (i_a_addr),
        .i_a_wdata  (i_a_wdata),
        .o_a_ready  (o_a_ready),
        .o_a_rvalid (o_a_rvalid),
        .o_a_rdata  (o_a_rdata),
        .i_b_valid  (i_b_valid),
        .i_b_wr     (i_b_wr),
        .i_b_addr   (i_b_addr),
        .i_b_wdata  (i_b_wdata),
        .o_b_ready  (o_b_ready),
        .o_b_rvalid (o_b_rvalid),
        .o_b_rdata  (o_b_rdata),
        .o_wr_en    (o_wr_en),
        .o_rd_en    (o_rd_en),
        .o_address  (o_address),
        .o_wr_data  (o_wr_data),
        .i_rd_data  (i_rd_data)
`ifdef SP_MEM_ARB_STATS_EN
       ,.o_a_grant_cnt  (o_a_grant_cnt),
        .o_b_grant_cnt  (o_b_grant_cnt),
        .o_conflict_cnt (o_conflict_cnt)
`endif
    );

    // Single-port memory: read data appears two cycles after the rd_en cycle.
    always @(posedge i_clk) begin
        if (o_rd_en) rdPipe1 <= mem[o_address];
        rdPipe2 <= rdPipe1;
        if (o_wr_en) mem[o_address] <= o_wr_data;
    end
    assign i_rd_data = rdPipe2;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                                 input logic bv, input logic bw, input logic [7:0] ba, input logic [7:0] bd);
        i_a_valid = av; i_a_wr = aw; i_a_addr = aa; i_a_wdata = ad;
        i_b_valid = bv; i_b_wr = bw; i_b_addr = ba; i_b_wdata = bd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCnt = checkCnt + 1;
        assert (observed === expected) passCnt = passCnt + 1;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        i_rst_n = 1'b0;
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        step();
        step();

        // Reset state, with A requesting to show ready is held low
        applyStimulus(1, 1, 8'h99, 8'h99, 0, 0, 8'h00, 8'h00);
        checkOutput("rst_a_ready", o_a_ready, 0);
        checkOutput("rst_wr_en", o_wr_en, 0);
        checkOutput("rst_rd_en", o_rd_en, 0);
        checkOutput("rst_address", o_address, 0);
        checkOutput("rst_wr_data", o_wr_data, 0);
        checkOutput("rst_rvalid", {o_a_rvalid, o_b_rvalid}, 0);
        i_rst_n = 1'b1;

        // A-only write 10 <= A5
        applyStimulus(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
        checkOutput("t1_a_ready", o_a_ready, 1);
        checkOutput("t1_b_ready", o_b_ready, 0);
        step();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("t1_wr_en", o_wr_en, 1);
        checkOutput("t1_rd_en", o_rd_en, 0);
        checkOutput("t1_address", o_address, 8'h10);
        checkOutput("t1_wr_data", o_wr_data, 8'hA5);
        step();
        checkOutput("t1_idle_wr_en", o_wr_en, 0);
        checkOutput("t1_hold_address", o_address, 8'h10);

        // B-only write 20 <= 5A, leaves last grant on B
        applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h5A);
        checkOutput("bw_b_ready", o_b_ready, 1);
        checkOutput("bw_a_ready", o_a_ready, 0);
        step();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("bw_wr_en", o_wr_en, 1);
        checkOutput("bw_address", o_address, 8'h20);
        checkOutput("bw_wr_data", o_wr_data, 8'h5A);
        step();

        // Contention: alternating reads A(10), B(20), A, B; returns three cycles after accept
        for (int c = 0; c < 7; c++) begin
            applyStimulus(c < 4, 0, 8'h10, 8'h00, c < 4, 0, 8'h20, 8'h00);
            checkOutput($sformatf("rr_a_ready_c%0d", c), o_a_ready, (c < 4) && (c % 2 == 0));
            checkOutput($sformatf("rr_b_ready_c%0d", c), o_b_ready, (c < 4) && (c % 2 == 1));
            checkOutput($sformatf("rr_rd_en_c%0d", c), o_rd_en, (c >= 1) && (c <= 4));
            if (c >= 1 && c <= 4)
                checkOutput($sformatf("rr_address_c%0d", c), o_address, (c % 2 == 1) ? 8'h10 : 8'h20);
            checkOutput($sformatf("rr_a_rvalid_c%0d", c), o_a_rvalid, (c == 3) || (c == 5));
            checkOutput($sformatf("rr_b_rvalid_c%0d", c), o_b_rvalid, (c == 4) || (c == 6));
            if (c == 3 || c == 5) checkOutput($sformatf("rr_a_rdata_c%0d", c), o_a_rdata, 8'hA5);
            if (c == 4 || c == 6) checkOutput($sformatf("rr_b_rdata_c%0d", c), o_b_rdata, 8'h5A);
            step();
        end

        // A wins alone, then loses contention to B, then is accepted with unchanged fields
        applyStimulus(1, 1, 8'h30, 8'h11, 0, 0, 8'h00, 8'h00);
        checkOutput("hold_a_ready0", o_a_ready, 1);
        step();
        applyStimulus(1, 0, 8'h40, 8'h00, 1, 1, 8'h50, 8'h22);
        checkOutput("hold_a_ready1", o_a_ready, 0);
        checkOutput("hold_b_ready1", o_b_ready, 1);
        checkOutput("hold_address1", o_address, 8'h30);
        step();
        applyStimulus(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("hold_a_ready2", o_a_ready, 1);
        checkOutput("hold_wr_en2", o_wr_en, 1);
        checkOutput("hold_address2", o_address, 8'h50);
        checkOutput("hold_wr_data2", o_wr_data, 8'h22);
        step();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("hold_rd_en3", o_rd_en, 1);
        checkOutput("hold_address3", o_address, 8'h40);
        step();
        step();
        step();

        // Read in flight, reset lands one cycle before its return
        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("mrst_a_ready0", o_a_ready, 1);
        step();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("mrst_rd_en1", o_rd_en, 1);
        step();
        i_rst_n = 1'b0;
        applyStimulus(1, 1, 8'h60, 8'h77, 1, 0, 8'h20, 8'h00);
        checkOutput("mrst_ready_in_rst", {o_a_ready, o_b_ready}, 0);
        step();
        i_rst_n = 1'b1;
        #1;
        checkOutput("mrst_rd_en3", o_rd_en, 0);
        checkOutput("mrst_address3", o_address, 0);
        checkOutput("mrst_wr_data3", o_wr_data, 0);
        checkOutput("mrst_rvalid3", {o_a_rvalid, o_b_rvalid}, 0);
        checkOutput("mrst_a_ready3", o_a_ready, 1);
        checkOutput("mrst_b_ready3", o_b_ready, 0);
        step();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("mrst_wr_en4", o_wr_en, 1);
        checkOutput("mrst_address4", o_address, 8'h60);
        checkOutput("mrst_rvalid4", {o_a_rvalid, o_b_rvalid}, 0);
        step();

        // Idle
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("idle_cmd_c%0d", c), {o_wr_en, o_rd_en}, 0);
            checkOutput($sformatf("idle_rvalid_c%0d", c), {o_a_rvalid, o_b_rvalid}, 0);
            checkOutput($sformatf("idle_ready_c%0d", c), {o_a_ready, o_b_ready}, 0);
            step();
        end

`ifdef SP_MEM_ARB_STATS_EN
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        #1;
        checkOutput("st_rst_conflict", o_conflict_cnt, 0);
        applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00);
        repeat (6) step();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("st_a_cnt", o_a_grant_cnt, 3);
        checkOutput("st_b_cnt", o_b_grant_cnt, 3);
        checkOutput("st_conflict", o_conflict_cnt, 6);
        applyStimulus(1, 1, 8'h70, 8'h00, 0, 0, 8'h00, 8'h00);
        repeat (70000) step();
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        checkOutput("st_a_sat", o_a_grant_cnt, 16'hFFFF);
        checkOutput("st_b_keep", o_b_grant_cnt, 3);
        checkOutput("st_conflict_keep", o_conflict_cnt, 6);
`endif

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
